// File: rtl/izh_pkg.sv
// Fixed-point helpers shared by the Izhikevich dv pipeline.
// Define DV_SATURATE_EN to clamp every mult/add result instead of wrapping.
package izh_pkg;

  localparam int N_DEF      = 20;
  localparam int Q_DEF      = 8;
  localparam int NUM_CH_DEF = 4;
  localparam int ID_W_DEF   = 2;

  // Raw Q8 coefficients: A = 0.04, B = 5.0, C = 140.0
  localparam int A_RAW_DEF = 10;
  localparam int B_RAW_DEF = 1280;
  localparam int C_RAW_DEF = 35840;

  typedef logic signed [N_DEF-1:0] fx_t;

  // Stage payload at the default configuration.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    fx_t                 step;
    fx_t                 data;
    logic                sat;
  } stage_pay_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } fx_res_t;

  // Bring a wide intermediate back into an n-bit two's complement range.
  function automatic fx_res_t fx_fit(input logic signed [63:0] x, input int n);
    fx_res_t r;
`ifdef DV_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (x < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end else begin
      r.val = x;
      r.sat = 1'b0;
    end
`else
    r.val = (x <<< (64 - n)) >>> (64 - n);
    r.sat = 1'b0;
`endif
    return r;
  endfunction

  // Full product, floor shift by q, then fit to n bits.
  function automatic fx_res_t fx_mul(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int n, input int q);
    logic signed [63:0] prod;
    prod = a * b;
    return fx_fit(prod >>> q, n);
  endfunction

  function automatic fx_res_t fx_add(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int n);
    return fx_fit(a + b, n);
  endfunction

  function automatic fx_res_t fx_sub(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int n);
    return fx_fit(a - b, n);
  endfunction

endpackage

// File: rtl/izh_pipe_stage.sv
// Generic pipeline register: captures on enable, holds otherwise.
// Payload only loads with a valid sample so bubbles leave the data untouched.
module izh_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/izh_dv_pipe.sv
// Three-stage handshaked Izhikevich update: dv = (A*v*v + B*v + C - w + i) * step.
// Optional clamping arithmetic via DV_SATURATE_EN (see izh_pkg).
module izh_dv_pipe
  import izh_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Q      = Q_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int A_COEF = A_RAW_DEF,
  parameter int B_COEF = B_RAW_DEF,
  parameter int C_COEF = C_RAW_DEF,
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ID_W-1:0]     in_id,
  input  logic signed [N-1:0] in_v,
  input  logic signed [N-1:0] in_w,
  input  logic signed [N-1:0] in_i,
  input  logic signed [N-1:0] in_step,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic signed [N-1:0] out_dv,
  output logic                out_sat
);

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic signed [N-1:0] step;
    logic signed [N-1:0] vv;
    logic signed [N-1:0] bv;
    logic signed [N-1:0] iw;
    logic                sat;
  } s1_t;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic signed [N-1:0] step;
    logic signed [N-1:0] data;
    logic                sat;
  } s2_t;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic signed [N-1:0] data;
    logic                sat;
  } s3_t;

  logic advance;
  logic s1_vld, s2_vld, s3_vld;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  // The whole pipe moves as one; it only freezes when a result is waiting.
  assign advance  = out_ready | ~s3_vld;
  assign in_ready = advance;

  always_comb begin
    fx_res_t vv, bv, iw;
    vv = fx_mul(longint'(in_v), longint'(in_v), N, Q);
    bv = fx_mul(longint'(B_COEF), longint'(in_v), N, Q);
    iw = fx_sub(longint'(in_i), longint'(in_w), N);
    s1_d.id   = in_id;
    s1_d.step = in_step;
    s1_d.vv   = N'(vv.val);
    s1_d.bv   = N'(bv.val);
    s1_d.iw   = N'(iw.val);
    s1_d.sat  = vv.sat | bv.sat | iw.sat;
  end

  izh_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (advance),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_vld),
    .data_o  (s1_q)
  );

  // Sum order is fixed so clamp points are reproducible: ((A*vv + bv) + C) + (i - w).
  always_comb begin
    fx_res_t av, t0, t1, t2;
    av = fx_mul(longint'(A_COEF), longint'(s1_q.vv), N, Q);
    t0 = fx_add(av.val, longint'(s1_q.bv), N);
    t1 = fx_add(t0.val, longint'(C_COEF), N);
    t2 = fx_add(t1.val, longint'(s1_q.iw), N);
    s2_d.id   = s1_q.id;
    s2_d.step = s1_q.step;
    s2_d.data = N'(t2.val);
    s2_d.sat  = s1_q.sat | av.sat | t0.sat | t1.sat | t2.sat;
  end

  izh_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (advance),
    .valid_i (s1_vld),
    .data_i  (s1_q2s2(s2_d)),
    .valid_o (s2_vld),
    .data_o  (s2_q)
  );

  always_comb begin
    fx_res_t m;
    m = fx_mul(longint'(s2_q.data), longint'(s2_q.step), N, Q);
    s3_d.id   = s2_q.id;
    s3_d.data = N'(m.val);
    s3_d.sat  = s2_q.sat | m.sat;
  end

  izh_pipe_stage #(.W($bits(s3_t))) u_s3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (advance),
    .valid_i (s2_vld),
    .data_i  (s3_d),
    .valid_o (s3_vld),
    .data_o  (s3_q)
  );

  function automatic s2_t s1_q2s2(input s2_t x);
    return x;
  endfunction

  assign out_valid = s3_vld;
  assign out_id    = s3_q.id;
  assign out_dv    = s3_q.data;
  assign out_sat   = s3_q.sat;

endmodule

// File: tb/tb_izh_dv_pipe.sv
// Directed self-checking bench for izh_dv_pipe at N=20, Q=8 defaults.
// Expected values are hand-computed; the saturation vector follows DV_SATURATE_EN.
module tb_izh_dv_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_id;
  logic signed [19:0] in_v;
  logic signed [19:0] in_w;
  logic signed [19:0] in_i;
  logic signed [19:0] in_step;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_id;
  logic signed [19:0] out_dv;
  logic               out_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  izh_dv_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_v      (in_v),
    .in_w      (in_w),
    .in_i      (in_i),
    .in_step   (in_step),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_dv    (out_dv),
    .out_sat   (out_sat)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Present one sample for a single accepting edge; called just after a posedge.
  task automatic applyStimulus(input logic [1:0] id, input int v, input int w,
                               input int i, input int step);
    in_valid = 1'b1;
    in_id    = id;
    in_v     = 20'(v);
    in_w     = 20'(w);
    in_i     = 20'(i);
    in_step  = 20'(step);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runOne(input string tag, input logic [1:0] id, input int v, input int w,
                        input int i, input int step, input int expDv, input int expSat);
    applyStimulus(id, v, w, i, step);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_early"}, longint'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, longint'(out_valid), 1);
    checkOutput({tag, "_dv"}, longint'(out_dv), longint'(expDv));
    checkOutput({tag, "_sat"}, longint'(out_sat), longint'(expSat));
    checkOutput({tag, "_id"}, longint'(out_id), longint'(id));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_drain"}, longint'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expRdy [12];
    int expVld [12];
    int expId  [12];
    int expDvT [4];
    int nextId;
    int emitted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_id     = '0;
    in_v      = '0;
    in_w      = '0;
    in_i      = '0;
    in_step   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", longint'(out_valid), 0);
    checkOutput("rst_dv", longint'(out_dv), 0);
    checkOutput("rst_id", longint'(out_id), 0);
    checkOutput("rst_sat", longint'(out_sat), 0);
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    runOne("base", 2'd0, 0, 0, 0, 256, 35840, 0);
    runOne("curr", 2'd1, 0, 0, 2560, 128, 19200, 0);
    runOne("v1", 2'd2, 256, 0, 0, 256, 37130, 0);
    runOne("negv", 2'd3, -256, 512, 0, 256, 34058, 0);
    runOne("floor", 2'd0, -256, 51200, 0, 77, -5002, 0);
`ifdef DV_SATURATE_EN
    runOne("big", 2'd1, 25600, 0, 0, 256, 184319, 1);
`else
    runOne("big", 2'd1, 25600, 0, 0, 256, 181920, 0);
`endif

    // Back-to-back ids 0..3, out_ready low in cycles 2..6.
    expRdy = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    expVld = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    expId  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    expDvT = '{35840, 36096, 36352, 36608};
    nextId  = 0;
    emitted = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (nextId < 4);
      in_id     = 2'(nextId);
      in_v      = '0;
      in_w      = '0;
      in_i      = 20'(nextId * 256);
      in_step   = 20'd256;
      @(negedge clk);
      checkOutput($sformatf("stall_rdy_c%0d", c), longint'(in_ready), longint'(expRdy[c]));
      checkOutput($sformatf("stall_vld_c%0d", c), longint'(out_valid), longint'(expVld[c]));
      if (expVld[c] == 1) begin
        checkOutput($sformatf("stall_id_c%0d", c), longint'(out_id), longint'(expId[c]));
        checkOutput($sformatf("stall_dv_c%0d", c), longint'(out_dv),
                    longint'(expDvT[expId[c]]));
      end
      if (out_valid && out_ready) emitted++;
      if (in_valid && in_ready) nextId++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stall_emitted", longint'(emitted), 4);
    checkOutput("stall_accepted", longint'(nextId), 4);

    // Reset with two samples still inside the pipe.
    applyStimulus(2'd1, 0, 0, 256, 256);
    applyStimulus(2'd2, 0, 0, 512, 256);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", longint'(out_valid), 0);
    checkOutput("flush_dv", longint'(out_dv), 0);
    checkOutput("flush_id", longint'(out_id), 0);
    checkOutput("flush_sat", longint'(out_sat), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("flush_stale_%0d", k), longint'(out_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
